// File: rtl/fb_writer.sv
// -----------------------------------------------------------------------------
// fb_writer
//
// Write side of the VGA frame buffer. Takes an 8-bit pixel stream with a
// valid/ready handshake, packs four pixels per 32-bit word (first pixel in
// [7:0]) and drives the frame RAM write port. A frame runs from a sof strobe
// until word WORDS-1 has been written; frame_done then pulses once.
//
// Optional feature: define FB_CLEAR_EN to add a `clear` input that, sampled in
// IDLE, writes zeros to the whole frame (clear has priority over sof).
//
// Ports:
//   clk        in   system / RAM write-port clock
//   reset      in   asynchronous, active-low reset
//   sof        in   start-of-frame strobe (sampled in IDLE and FILL)
//   clear      in   frame clear request, IDLE only (FB_CLEAR_EN builds only)
//   pix_valid  in   pixel present on pix_data
//   pix_data   in   8-bit pixel
//   pix_ready  out  pixel accepted this cycle when pix_valid is also high
//   wraddress  out  RAM word address (holds when wren=0)
//   data       out  RAM write data   (holds when wren=0)
//   wren       out  RAM write enable, one cycle per word
//   busy       out  frame fill (or clear) in progress
//   frame_done out  one-cycle pulse after the last word of a frame is written
// -----------------------------------------------------------------------------
module fb_writer #(
  parameter int HRES  = 640,
  parameter int VRES  = 480,
  parameter int WORDS = HRES * VRES / 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sof,
`ifdef FB_CLEAR_EN
  input  logic        clear,
`endif
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  output logic        pix_ready,
  output logic [16:0] wraddress,
  output logic [31:0] data,
  output logic        wren,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [16:0] LAST_ADDR = 17'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DONE
`ifdef FB_CLEAR_EN
    , S_CLEAR
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [16:0] addr_q, addr_d;         // address of the word being assembled
  logic [1:0]  lane_q, lane_d;         // byte lane for the next accepted pixel
  logic [31:0] pack_q, pack_d;         // lanes 0..2 of the word in progress
  logic [16:0] wraddress_q, wraddress_d;
  logic [31:0] data_q, data_d;
  logic        wren_q, wren_d;
  logic        frame_done_q, frame_done_d;
  logic        accept;

  assign pix_ready  = (state_q == S_FILL);
  assign accept     = pix_valid && pix_ready;
  assign wraddress  = wraddress_q;
  assign data       = data_q;
  assign wren       = wren_q;
  assign frame_done = frame_done_q;
`ifdef FB_CLEAR_EN
  assign busy = (state_q == S_FILL) || (state_q == S_CLEAR);
`else
  assign busy = (state_q == S_FILL);
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; an unassigned path would infer a latch.
    state_d      = state_q;
    addr_d       = addr_q;
    lane_d       = lane_q;
    pack_d       = pack_q;
    wraddress_d  = wraddress_q;
    data_d       = data_q;
    wren_d       = 1'b0;
    frame_done_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
`ifdef FB_CLEAR_EN
        if (clear) begin
          state_d = S_CLEAR;
          addr_d  = '0;
        end else
`endif
        if (sof) begin
          state_d = S_FILL;
          addr_d  = '0;
          lane_d  = '0;
          pack_d  = '0;
        end
      end

      S_FILL: begin
        if (sof) begin
          // Abort: drop the partial word, including a pixel accepted now.
          addr_d = '0;
          lane_d = '0;
          pack_d = '0;
        end else if (accept) begin
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            wren_d      = 1'b1;
            wraddress_d = addr_q;
            data_d      = {pix_data, pack_q[23:0]};
            if (addr_q == LAST_ADDR) state_d = S_DONE;
            else                     addr_d  = addr_q + 17'd1;
          end else begin
            pack_d[{lane_q, 3'b000} +: 8] = pix_data;
          end
        end
      end

      // The final word's wren is visible in this state; frame_done follows.
      S_DONE: begin
        frame_done_d = 1'b1;
        state_d      = S_IDLE;
      end

`ifdef FB_CLEAR_EN
      S_CLEAR: begin
        wren_d      = 1'b1;
        wraddress_d = addr_q;
        data_d      = '0;
        if (addr_q == LAST_ADDR) state_d = S_DONE;
        else                     addr_d  = addr_q + 17'd1;
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      lane_q       <= '0;
      pack_q       <= '0;
      wraddress_q  <= '0;
      data_q       <= '0;
      wren_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      lane_q       <= lane_d;
      pack_q       <= pack_d;
      wraddress_q  <= wraddress_d;
      data_q       <= data_d;
      wren_q       <= wren_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_fb_writer.sv
// -----------------------------------------------------------------------------
// tb_fb_writer
//
// Directed + randomized bench for fb_writer on a reduced 16x8 frame
// (32 words). A transaction-level model keeps the accepted pixels of the
// current word in a queue and predicts each RAM write one cycle after the
// fourth pixel, frame_done one cycle after the last write, and the
// pix_ready/busy levels. All DUT outputs are compared every cycle.
// -----------------------------------------------------------------------------
module tb_fb_writer;

  localparam int HRES  = 16;
  localparam int VRES  = 8;
  localparam int WORDS = HRES * VRES / 4;
`ifdef FB_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        sof;
`ifdef FB_CLEAR_EN
  logic        clear;
`endif
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        pix_ready;
  logic [16:0] wraddress;
  logic [31:0] data;
  logic        wren;
  logic        busy;
  logic        frame_done;

  always #5 clk = ~clk;

  fb_writer #(.HRES(HRES), .VRES(VRES)) dut (
    .clk        (clk),
    .reset      (reset),
    .sof        (sof),
`ifdef FB_CLEAR_EN
    .clear      (clear),
`endif
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_ready  (pix_ready),
    .wraddress  (wraddress),
    .data       (data),
    .wren       (wren),
    .busy       (busy),
    .frame_done (frame_done)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_fill;          // frame in progress: pixels are taken
  bit          m_clr;           // clear in progress
  logic [7:0]  m_q[$];          // pixels of the word being assembled
  int          m_addr;          // word index of the next fill write
  int          m_clr_addr;      // word index of the next clear write
  int          done_cd;         // cycles until frame_done is scheduled
  logic [16:0] m_last_addr;     // RAM port holds its last write
  logic [31:0] m_last_data;
  int          wr_seen;
  int          done_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fill      = 1'b0;
    m_clr       = 1'b0;
    m_q.delete();
    m_addr      = 0;
    m_clr_addr  = 0;
    done_cd     = 0;
    m_last_addr = '0;
    m_last_data = '0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_wren",       32'(wren),       32'd0);
    chk("rst_wraddress",  32'(wraddress),  32'd0);
    chk("rst_data",       data,            32'd0);
    chk("rst_pix_ready",  32'(pix_ready),  32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
  endtask

  // One clock cycle: drive inputs after the falling edge, predict, then
  // compare outputs 1 ns after the rising edge.
  task automatic cyc(input bit s, input bit v, input logic [7:0] d, input bit c = 1'b0);
    bit          nxt_wren = 1'b0;
    bit          nxt_done = 1'b0;
    logic [16:0] nxt_addr = '0;
    logic [31:0] nxt_data = '0;
    bit          idle;
    @(negedge clk);
    sof       = s;
    pix_valid = v;
    pix_data  = d;
`ifdef FB_CLEAR_EN
    clear     = c;
`endif
    #1;
    chk("pix_ready", 32'(pix_ready), 32'(m_fill));
    chk("busy",      32'(busy),      32'(m_fill || m_clr));

    idle = !m_fill && !m_clr && (done_cd == 0);
    if (done_cd != 0) begin
      done_cd--;
      nxt_done = (done_cd == 0);
    end

    if (m_clr) begin
      nxt_wren = 1'b1;
      nxt_addr = 17'(m_clr_addr);
      nxt_data = '0;
      if (m_clr_addr == WORDS - 1) begin
        m_clr   = 1'b0;
        done_cd = 1;
      end else m_clr_addr++;
    end else if (m_fill) begin
      if (s) begin
        m_q.delete();
        m_addr = 0;
      end else if (v) begin
        m_q.push_back(d);
        if (m_q.size() == 4) begin
          nxt_wren = 1'b1;
          nxt_addr = 17'(m_addr);
          nxt_data = {m_q[3], m_q[2], m_q[1], m_q[0]};
          m_q.delete();
          if (m_addr == WORDS - 1) begin
            m_fill  = 1'b0;
            done_cd = 1;
          end else m_addr++;
        end
      end
    end else if (idle) begin
      if (c && CLEAR_EN) begin
        m_clr      = 1'b1;
        m_clr_addr = 0;
      end else if (s) begin
        m_fill = 1'b1;
        m_addr = 0;
        m_q.delete();
      end
    end

    @(posedge clk);
    #1;
    if (nxt_wren) begin
      m_last_addr = nxt_addr;
      m_last_data = nxt_data;
    end
    chk("wren",       32'(wren),       32'(nxt_wren));
    chk("wraddress",  32'(wraddress),  32'(m_last_addr));
    chk("data",       data,            m_last_data);
    chk("frame_done", 32'(frame_done), 32'(nxt_done));
    if (wren)       wr_seen++;
    if (frame_done) done_seen++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit         v;
    logic [7:0] d;
    int         acc;

    // ---- reset state ----
    reset = 1'b0; sof = 1'b0; pix_valid = 1'b0; pix_data = '0;
`ifdef FB_CLEAR_EN
    clear = 1'b0;
`endif
    model_reset();
    #12;
    check_reset_outputs();
    @(negedge clk) reset = 1'b1;
    cyc(0, 1, 8'h77);                       // valid before sof is ignored

    // ---- single word 0x44332211 at address 0 ----
    wr_seen = 0;
    cyc(1, 0, 8'h00);
    cyc(0, 1, 8'h11); cyc(0, 1, 8'h22); cyc(0, 1, 8'h33); cyc(0, 1, 8'h44);
    cyc(0, 0, 8'h00); cyc(0, 0, 8'h00);
    chk("one_word_writes", 32'(wr_seen), 32'd1);

    // ---- random valid gaps, 12 pixels after a restart ----
    wr_seen = 0;
    cyc(1, 0, 8'h00);
    acc = 0;
    while (acc < 12) begin
      v = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      cyc(0, v, d);
      if (v) acc++;
    end
    cyc(0, 0, 8'h00);
    chk("gap_writes", 32'(wr_seen), 32'd3);

    // ---- abort after 6 pixels, then 0xA0..0xA3 ----
    cyc(1, 0, 8'h00);
    for (int i = 0; i < 6; i++) cyc(0, 1, 8'($urandom));
    cyc(1, 0, 8'h00);
    for (int i = 0; i < 4; i++) cyc(0, 1, 8'hA0 + 8'(i));
    cyc(0, 0, 8'h00);

    // ---- sof coinciding with the 4th pixel discards that word ----
    for (int i = 0; i < 3; i++) cyc(0, 1, 8'($urandom));
    wr_seen = 0;
    cyc(1, 1, 8'h99);
    cyc(0, 0, 8'h00);
    chk("abort_4th_writes", 32'(wr_seen), 32'd0);

    // ---- full frame at full rate, sof in DONE ignored ----
    wr_seen = 0; done_seen = 0;
    cyc(1, 0, 8'h00);
    for (int i = 0; i < WORDS * 4; i++) cyc(0, 1, 8'($urandom));
    cyc(1, 1, 8'h55);
    for (int i = 0; i < 3; i++) cyc(0, 1, 8'($urandom));
    chk("frame_writes", 32'(wr_seen), 32'(WORDS));
    chk("frame_done_count", 32'(done_seen), 32'd1);

    // ---- full frame with random gaps ----
    wr_seen = 0; done_seen = 0;
    cyc(1, 0, 8'h00);
    acc = 0;
    while (acc < WORDS * 4) begin
      v = 1'($urandom_range(0, 1));
      cyc(0, v, 8'($urandom));
      if (v) acc++;
    end
    for (int i = 0; i < 3; i++) cyc(0, 0, 8'h00);
    chk("gap_frame_writes", 32'(wr_seen), 32'(WORDS));
    chk("gap_frame_done_count", 32'(done_seen), 32'd1);

    // ---- asynchronous reset mid-frame after 10 words ----
    cyc(1, 0, 8'h00);
    for (int i = 0; i < 40; i++) cyc(0, 1, 8'($urandom));
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    sof = 1'b0; pix_valid = 1'b0;
    @(negedge clk) reset = 1'b1;
    cyc(0, 1, 8'h66);                       // not accepted, pix_ready low
    cyc(0, 1, 8'h67);
    cyc(1, 0, 8'h00);
    cyc(0, 1, 8'hC0); cyc(0, 1, 8'hC1); cyc(0, 1, 8'hC2); cyc(0, 1, 8'hC3);
    cyc(0, 0, 8'h00);

`ifdef FB_CLEAR_EN
    // ---- clear wins over sof; sof during clear ignored ----
    cyc(1, 0, 8'h00);                       // abort the open frame first
    for (int i = 0; i < WORDS * 4; i++) cyc(0, 1, 8'($urandom));
    for (int i = 0; i < 3; i++) cyc(0, 0, 8'h00);
    wr_seen = 0; done_seen = 0;
    cyc(1, 0, 8'h00, 1'b1);
    for (int i = 0; i < WORDS + 3; i++) cyc(i == 5, 1, 8'hEE, 1'b0);
    chk("clear_writes", 32'(wr_seen), 32'(WORDS));
    chk("clear_done_count", 32'(done_seen), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
